// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Signal bundle that connects the requesters and the UART transmitter to
//   uart_tx_arbiter.
//
//   Modports
//     master : the arbiter. It drives req_ready, tx_start, tx_in, grant and
//              timeout_err. It samples req_valid, req_data and tx_dv.
//     slave  : the surrounding environment (requesters plus the transmitter),
//              seen from the other side of the same signals.
//
//   Signals
//     req_valid   [NUM_REQ]            per-requester byte-pending flag
//     req_data    [NUM_REQ*DATA_WIDTH] requester i's byte in [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready   [NUM_REQ]            one-hot acceptance pulse
//     tx_start                         one-cycle launch pulse to the transmitter
//     tx_in       [DATA_WIDTH]         byte presented to the transmitter
//     tx_dv                            transmitter idle flag (high = idle)
//     grant       [NUM_REQ]            one-hot owner of the current frame
//     timeout_err                      sticky "transmitter never started" flag
//     req_lock    [NUM_REQ]            only when UART_TX_ARB_LOCK_EN is defined
//
//   Build option: define UART_TX_ARB_LOCK_EN to add req_lock.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_start;
  logic [DATA_WIDTH-1:0]         tx_in;
  logic                          tx_dv;
  logic [NUM_REQ-1:0]            grant;
  logic                          timeout_err;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]            req_lock;

  modport master (
    input  req_valid, req_data, tx_dv, req_lock,
    output req_ready, tx_start, tx_in, grant, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_dv, req_lock,
    input  req_ready, tx_start, tx_in, grant, timeout_err
  );
`else
  modport master (
    input  req_valid, req_data, tx_dv,
    output req_ready, tx_start, tx_in, grant, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_dv,
    input  req_ready, tx_start, tx_in, grant, timeout_err
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one UART
//   transmitter. Each accepted byte is latched and launched with a one-cycle
//   tx_start pulse. The block then follows the transmitter's tx_dv (idle) flag
//   through the frame. If the transmitter never drops tx_dv within
//   START_TIMEOUT cycles of the launch, the byte is dropped and the sticky
//   timeout_err flag is set.
//
//   Ports
//     clk  : single clock, all logic on posedge
//     rst  : synchronous, active-high reset
//     bus  : uart_tx_arbiter_if.master (requester and transmitter signals)
//
//   Parameters
//     NUM_REQ       : number of requesters (2..8)
//     DATA_WIDTH    : byte width handed to the transmitter
//     START_TIMEOUT : cycles allowed for tx_dv to fall after tx_start
//
//   Build option: define UART_TX_ARB_LOCK_EN to add req_lock. A requester
//   whose lock bit is set when its byte is accepted is preferred on the next
//   selection, as long as it is still valid.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | waiting for a valid request while the transmitter is idle
//   LAUNCH    | byte latched; pulse tx_start this cycle
//   WAIT_BUSY | waiting for the transmitter to drop tx_dv (timeout armed)
//   WAIT_DONE | frame in flight; waiting for tx_dv to return high
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int START_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_arbiter_if.master     bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so that rr_ptr + k cannot overflow before the wrap.
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  logic [1:0]             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       gnt_idx;
  logic [CNT_W-1:0]       cnt;

  logic [NUM_REQ-1:0]     req_ready_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic                   tx_start_q;
  logic [DATA_WIDTH-1:0]  tx_in_q;
  logic                   timeout_q;

  logic [SUM_W-1:0]       cand;
  logic [IDX_W-1:0]       rr_idx;
  logic                   rr_found;
  logic [IDX_W-1:0]       sel_idx;
  logic [NUM_REQ-1:0]     sel_onehot;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   accept;

  // Round-robin search. Start one past the last requester that completed a
  // frame and take the first valid requester, wrapping modulo NUM_REQ.
  always_comb begin
    cand     = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!rr_found && bus.req_valid[cand[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IDX_W-1:0];
      end
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic             lock_on;
  logic [IDX_W-1:0] lock_idx;

  // A locked requester jumps the round-robin order only while it is valid.
  always_comb begin
    sel_idx = rr_idx;
    if (lock_on && bus.req_valid[lock_idx]) begin
      sel_idx = lock_idx;
    end
  end

  // Lock state is refreshed on every acceptance. It is taken from the lock bit
  // that belongs to the requester whose byte was just taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_on  <= 1'b0;
      lock_idx <= '0;
    end else if (accept) begin
      lock_on  <= bus.req_lock[sel_idx];
      lock_idx <= sel_idx;
    end
  end
`else
  assign sel_idx = rr_idx;
`endif

  assign sel_onehot = NUM_REQ'(1) << sel_idx;
  assign sel_data   = bus.req_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Requests are only looked at in IDLE. Changes to req_valid at any other
  // time have no effect.
  assign accept = (state == IDLE) && bus.tx_dv && rr_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= LAST_IDX;
      gnt_idx     <= '0;
      cnt         <= '0;
      req_ready_q <= '0;
      grant_q     <= '0;
      tx_start_q  <= 1'b0;
      tx_in_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            gnt_idx     <= sel_idx;
            grant_q     <= sel_onehot;
            req_ready_q <= sel_onehot;
            tx_in_q     <= sel_data;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_start_q <= 1'b1;
          cnt        <= '0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // The transmitter starting wins over a timeout in the same cycle.
          if (!bus.tx_dv) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            // The byte is dropped. rr_ptr is left alone, so the same requester
            // is still next in line.
            timeout_q <= 1'b1;
            grant_q   <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (bus.tx_dv) begin
            rr_ptr  <= gnt_idx;
            grant_q <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.grant       = grant_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_in       = tx_in_q;
  assign bus.timeout_err = timeout_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant_q));
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready_q));
  a_ready_then_start: assert property (@(posedge clk) disable iff (rst)
    (|req_ready_q) |=> tx_start_q);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int ST = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .START_TIMEOUT(ST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait expired (cycle %0d)", name, cyc);
  endtask

  // Transmitter model.
  //   mode 0: reacts to tx_start, after 0..3 cycles drops tx_dv for 1..6 cycles
  //   mode 1: dead transmitter, tx_dv held high
  //   mode 2: tx_dv taken from man_dv
  int   tx_mode = 0;
  logic man_dv  = 1'b1;
  logic xm_dv   = 1'b1;
  logic xm_busy = 1'b0;
  logic xm_pend = 1'b0;
  int   xm_cnt  = 0;

  always @(posedge clk) begin
    if (rst) begin
      xm_dv <= 1'b1; xm_busy <= 1'b0; xm_pend <= 1'b0; xm_cnt <= 0;
    end else if (xm_pend) begin
      if (xm_cnt == 0) begin
        xm_dv <= 1'b0; xm_busy <= 1'b1; xm_pend <= 1'b0;
        xm_cnt <= int'($urandom_range(1, 6));
      end else begin
        xm_cnt <= xm_cnt - 1;
      end
    end else if (xm_busy) begin
      if (xm_cnt <= 1) begin
        xm_dv <= 1'b1; xm_busy <= 1'b0;
      end else begin
        xm_cnt <= xm_cnt - 1;
      end
    end else if (bus.tx_start && tx_mode == 0) begin
      xm_pend <= 1'b1;
      xm_cnt  <= int'($urandom_range(0, 3));
    end
  end

  assign bus.tx_dv = (tx_mode == 1) ? 1'b1 : (tx_mode == 2) ? man_dv : xm_dv;

  // Reference model, tracked per frame.
  //   A frame is accepted at some edge.
  //   Its tx_start comes one edge later.
  //   It then waits for tx_dv to fall and afterwards to rise again.
  //   It is abandoned if tx_dv is still high ST cycles after the tx_start pulse.
  int   m_owner = -1;
  int   m_last  = N - 1;
  int   m_age   = 0;
  bit   m_started = 1'b0;
  logic [DW-1:0] m_byte = '0;
  logic m_terr = 1'b0;
  bit   m_lock_on = 1'b0;
  int   m_lock_idx = 0;
  bit   model_ok = 1'b0;

  logic [N-1:0]  exp_ready = '0;
  logic [N-1:0]  exp_grant = '0;
  logic          exp_start = 1'b0;

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    exp_ready = '0;
    exp_start = 1'b0;
    if (rst) begin
      model_ok = 1'b1;
      m_owner = -1; m_last = N - 1; m_terr = 1'b0; m_byte = '0;
      m_lock_on = 1'b0; m_lock_idx = 0;
    end else if (m_owner < 0) begin
      if (bus.tx_dv && (|bus.req_valid)) begin
        if (m_lock_on && bus.req_valid[m_lock_idx]) m_owner = m_lock_idx;
        else m_owner = rr_pick(m_last, bus.req_valid);
        m_age = 0;
        m_started = 1'b0;
        m_byte = bus.req_data[m_owner*DW +: DW];
        exp_ready[m_owner] = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
        m_lock_on  = bus.req_lock[m_owner];
        m_lock_idx = m_owner;
`endif
      end
    end else begin
      m_age++;
      if (m_age == 1) exp_start = 1'b1;
      else if (!m_started) begin
        if (!bus.tx_dv) m_started = 1'b1;
        else if (m_age == ST + 1) begin
          m_terr = 1'b1;
          m_owner = -1;
        end
      end else if (bus.tx_dv) begin
        m_last = m_owner;
        m_owner = -1;
      end
    end
    exp_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("req_ready",   32'(bus.req_ready),   32'(exp_ready));
      check("grant",       32'(bus.grant),       32'(exp_grant));
      check("tx_start",    32'(bus.tx_start),    32'(exp_start));
      check("tx_in",       32'(bus.tx_in),       32'(m_byte));
      check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  function automatic int ready_idx();
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) return i;
    return -1;
  endfunction

  task automatic wait_accept(output int idx, input int budget, input bit rand_data);
    idx = -1;
    for (int c = 0; c < budget; c++) begin
      if (rand_data) bus.req_data = $urandom;
      step();
      if (|bus.req_ready) begin
        idx = ready_idx();
        return;
      end
    end
    fail("accept_wait");
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      step();
      if (bus.grant == '0 && bus.tx_dv) return;
    end
    fail("idle_wait");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  int idx;
  int n;
  int last_acc;
  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef UART_TX_ARB_LOCK_EN
  int exp_lock[5] = '{0, 0, 0, 0, 1};
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
`ifdef UART_TX_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
    #1;
    // Reset state
    repeat (3) begin
      step();
      check("rst_grant",   32'(bus.grant), 32'h0);
      check("rst_ready",   32'(bus.req_ready), 32'h0);
      check("rst_start",   32'(bus.tx_start), 32'h0);
      check("rst_tx_in",   32'(bus.tx_in), 32'h0);
      check("rst_timeout", 32'(bus.timeout_err), 32'h0);
    end
    rst = 1'b0;

    // Single request, byte 0x5A from requester 0
    bus.req_data  = 32'hC3A7_E15A;
    bus.req_valid = 4'b0001;
    wait_accept(idx, 10, 1'b0);
    check("single_ready", 32'(bus.req_ready), 32'h1);
    check("single_grant", 32'(bus.grant), 32'h1);
    check("single_nostart", 32'(bus.tx_start), 32'h0);
    bus.req_valid = '0;
    bus.req_data  = $urandom;
    step();
    check("single_start", 32'(bus.tx_start), 32'h1);
    check("single_tx_in", 32'(bus.tx_in), 32'h5A);
    check("single_grant_hold", 32'(bus.grant), 32'h1);
    wait_idle(60);

    // Fairness with all four requesters held valid
    do_reset(2);
    bus.req_valid = 4'hF;
    last_acc = 0;
    for (int f = 0; f < 8; f++) begin
      wait_accept(idx, 80, 1'b1);
      check("fair_order", 32'(idx), 32'(exp_order[f]));
      if (f > 0) check("fair_spacing", 32'(cyc - last_acc >= 4), 32'h1);
      last_acc = cyc;
    end
    bus.req_valid = '0;
    wait_idle(60);

    // Timeout with a dead transmitter
    do_reset(2);
    tx_mode = 1;
    bus.req_valid = 4'b0100;
    wait_accept(idx, 10, 1'b0);
    check("to_grant_idx", 32'(idx), 32'h2);
    bus.req_valid = '0;
    step();
    check("to_start", 32'(bus.tx_start), 32'h1);
    n = 0;
    while (!bus.timeout_err && n < ST + 10) begin
      step();
      n++;
    end
    check("to_latency", 32'(n), 32'(ST));
    check("to_grant_clear", 32'(bus.grant), 32'h0);
    tx_mode = 0;
    bus.req_valid = 4'hF;
    wait_accept(idx, 10, 1'b0);
    check("to_rr_unchanged", 32'(idx), 32'h0);
    bus.req_valid = '0;
    check("to_sticky", 32'(bus.timeout_err), 32'h1);

    // Reset while requester 0's frame is in flight
    n = 0;
    while (bus.tx_dv && n < 20) begin
      step();
      n++;
    end
    if (bus.tx_dv) fail("midrst_busy_wait");
    step();
    rst = 1'b1;
    step();
    check("midrst_ready", 32'(bus.req_ready), 32'h0);
    check("midrst_start", 32'(bus.tx_start), 32'h0);
    check("midrst_grant", 32'(bus.grant), 32'h0);
    check("midrst_tx_in", 32'(bus.tx_in), 32'h0);
    check("midrst_timeout", 32'(bus.timeout_err), 32'h0);
    rst = 1'b0;
    bus.req_valid = 4'hF;
    wait_accept(idx, 10, 1'b0);
    check("midrst_next_grant", 32'(idx), 32'h0);
    bus.req_valid = '0;
    wait_idle(60);

    // Busy gating: tx_dv low in IDLE
    tx_mode = 2;
    man_dv = 1'b0;
    bus.req_valid = 4'b0010;
    repeat (5) begin
      step();
      check("gate_no_ready", 32'(bus.req_ready), 32'h0);
    end
    man_dv = 1'b1;
    step();
    check("gate_accept", 32'(bus.req_ready), 32'h2);
    bus.req_valid = '0;
    step();
    check("gate_start", 32'(bus.tx_start), 32'h1);
    repeat (2) step();
    man_dv = 1'b0;
    repeat (3) step();
    man_dv = 1'b1;
    wait_idle(10);
    tx_mode = 0;

`ifdef UART_TX_ARB_LOCK_EN
    // Lock keeps requester 0 for three extra bytes
    do_reset(2);
    bus.req_valid = 4'b0011;
    bus.req_lock  = 4'b0001;
    for (int f = 0; f < 5; f++) begin
      wait_accept(idx, 80, 1'b1);
      check("lock_order", 32'(idx), 32'(exp_lock[f]));
      if (f == 2) bus.req_lock = '0;
    end
    bus.req_valid = '0;
    wait_idle(60);
`endif

    // Randomized traffic checked by the model every cycle
    do_reset(2);
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 3) == 0) bus.req_valid = N'($urandom);
      bus.req_data = $urandom;
`ifdef UART_TX_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) bus.req_lock = N'($urandom);
`endif
      if ($urandom_range(0, 149) == 0) begin
        n = int'($urandom_range(0, 9));
        tx_mode = (n < 7) ? 0 : (n < 9) ? 1 : 2;
      end
      if ($urandom_range(0, 2) == 0) man_dv = 1'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    tx_mode = 0;
    bus.req_valid = '0;
    wait_idle(ST + 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
